// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register stage with hold, bubble and flush
// control, plus saturating performance counters for each stall action.
//
// Ports:
//   clk        clock; every output is a flop updated on its rising edge
//   rst        synchronous active-high reset
//   stall      stall vector; bit STAGE bubbles, bit STAGE+1 holds
//   flush      squash the stage contents (branch redirect)
//   clr_cnt    synchronous clear of the three counters
//   in_valid   upstream payload valid
//   in_data    upstream payload
//   out_valid  registered valid
//   out_data   registered payload (zero whenever out_valid is 0)
//   hold_cnt   saturating count of HOLD cycles
//   bubble_cnt saturating count of BUBBLE cycles
//   kill_cnt   saturating count of valid entries squashed by flush

module pipe_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int STAGE   = 3,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               clr_cnt,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   kill_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  kill_cnt_q, kill_cnt_d;

  logic hold_req;
  logic bubble_req;
  logic act_flush;
  logic act_hold;
  logic act_bubble;
  logic act_load;

  // The last stage in the vector has no stage after it to hold it.
  if (STAGE + 1 < STALL_W) begin : g_hold
    assign hold_req = stall[STAGE+1];
  end else begin : g_no_hold
    assign hold_req = 1'b0;
  end

  assign bubble_req = stall[STAGE];

  // Other stall bits belong to other stages.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Exactly one action per cycle; reset is handled in the flops.
  always_comb begin
    act_flush  = flush;
    act_hold   = !flush && hold_req;
    act_bubble = !flush && !hold_req && bubble_req;
    act_load   = !flush && !hold_req && !bubble_req;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (1'b1)
      act_flush, act_bubble: begin
        valid_d = 1'b0;
        data_d  = '0;
      end
      act_hold: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
      act_load: begin
        valid_d = in_valid;
        data_d  = in_valid ? in_data : '0;
      end
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Clear wins over any increment on the same edge.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    kill_cnt_d   = kill_cnt_q;
    if (clr_cnt) begin
      hold_cnt_d   = '0;
      bubble_cnt_d = '0;
      kill_cnt_d   = '0;
    end else begin
      if (act_hold)
        hold_cnt_d = sat_inc(hold_cnt_q);
      if (act_bubble)
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      if (act_flush && valid_q)
        kill_cnt_d = sat_inc(kill_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      hold_cnt_q   <= '0;
      bubble_cnt_q <= '0;
      kill_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      hold_cnt_q   <= hold_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      kill_cnt_q   <= kill_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign hold_cnt   = hold_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign kill_cnt   = kill_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the payload carried by the stage.
REQ-002 Parameter STAGE, default 3, SHALL set the index of the stall bit that inserts a bubble; bit STAGE+1 SHALL hold the stage.
REQ-003 Parameter STALL_W, default 6, SHALL set the width of the stall vector; legal range STAGE < STALL_W.
REQ-004 Parameter CNT_W, default 16, SHALL set the width of each performance counter.
REQ-005 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-006 Port list, in this order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  STALL_W  pipeline stall vector from the stall controller
- flush  in  1  squash the stage contents (branch redirect)
- clr_cnt  in  1  synchronous clear of the performance counters
- in_valid  in  1  upstream payload valid
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  registered valid
- out_data  out  DATA_W  registered payload
- hold_cnt  out  CNT_W  count of hold cycles
- bubble_cnt  out  CNT_W  count of bubble cycles
- kill_cnt  out  CNT_W  count of valid entries squashed by flush

Function
REQ-007 All outputs SHALL be registered and SHALL update only on the rising edge of clk.
REQ-008 Each cycle SHALL take exactly one action, in this priority order: rst > flush > HOLD > BUBBLE > LOAD.
REQ-009 HOLD SHALL occur when STAGE+1 < STALL_W and stall[STAGE+1]=1. In HOLD, out_valid and out_data SHALL keep their values.
REQ-010 When STAGE = STALL_W-1, the HOLD condition SHALL be constant 0.
REQ-011 BUBBLE SHALL occur when stall[STAGE]=1 and the stage is not in HOLD. In BUBBLE: out_valid<=0 and out_data<=0.
REQ-012 LOAD SHALL occur when neither stall bit is set. In LOAD: out_valid<=in_valid; out_data<=in_data when in_valid=1, else out_data<=0.
REQ-013 flush SHALL force out_valid<=0 and out_data<=0 regardless of stall, including during HOLD.
REQ-014 Latency from in_* to out_* SHALL be 1 cycle in LOAD; there SHALL be no combinational path from any input to any output.
REQ-015 Stall bits other than STAGE and STAGE+1 SHALL have no effect.
REQ-016 hold_cnt SHALL increment by 1 in each HOLD cycle.
REQ-017 bubble_cnt SHALL increment by 1 in each BUBBLE cycle.
REQ-018 kill_cnt SHALL increment by 1 in each flush cycle in which out_valid=1 before the edge.
REQ-019 Each counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 clr_cnt=1 SHALL zero all three counters on that edge and SHALL take priority over their increments; it SHALL NOT affect out_valid or out_data.
REQ-021 Counter behaviour SHALL follow the action actually taken under REQ-008. A flush cycle SHALL NOT count as HOLD or BUBBLE even when stall bits are set.

Reset
REQ-022 When rst=1 at a clock edge: out_valid<=0, out_data<=0, hold_cnt<=0, bubble_cnt<=0, kill_cnt<=0, regardless of every other input.
REQ-023 Reset during HOLD or flush SHALL discard the held contents. On the first edge after rst deasserts, the block SHALL perform a normal LOAD, BUBBLE or HOLD.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios with default parameters:
- Load: in_valid=1, in_data=0x1234ABCD, stall=0 -> next cycle out_valid=1, out_data=0x1234ABCD; all counters 0.
- Hold: load 0xDEADBEEF, then stall=6'b010000 for 3 cycles with in_data changing -> out_data stays 0xDEADBEEF; hold_cnt=3; bubble_cnt=0.
- Bubble: out_valid=1, then stall=6'b001000 for 1 cycle -> out_valid=0, out_data=0, bubble_cnt=1; stall=0 with in_valid=1, in_data=0x5 -> out_data=0x5.
- Flush over hold: out_valid=1, stall=6'b011000 and flush=1 -> out_valid=0, out_data=0, kill_cnt=1, hold_cnt unchanged; a second flush with out_valid=0 -> kill_cnt stays 1.
- Saturation and clear, with CNT_W=2: 5 HOLD cycles -> hold_cnt=3; clr_cnt=1 during a 6th HOLD -> hold_cnt=0.
- Reset mid-hold: rst=1 while stall[4]=1 and out_valid=1 -> all outputs 0 next cycle; rst=0 with stall=0, in_valid=1, in_data=0x77 -> out_data=0x77.
